// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
//   Issue controller sitting between decode and execute. Each cycle it decides
//   whether the decoded instruction may enter execute, keeps a per-register
//   pending-write scoreboard, and holds fetch while a control transfer is in
//   flight. All state advances on the falling edge of I_CLOCK.
//
// Ports
//   I_CLOCK       pipeline clock (state updates on falling edge)
//   I_RESET       asynchronous active-high reset
//   I_LOCK        pipeline enable; low freezes state and parks the FSM in HALT
//   I_DecValid    decode presents an instruction
//   I_Src1Idx/Use source-1 register index / read enable
//   I_Src2Idx/Use source-2 register index / read enable
//   I_DestIdx     destination register index
//   I_DestWrite   instruction writes I_DestIdx
//   I_IsCtrl      instruction is a branch/JMP/JSR/JSRR
//   I_WBValid     writeback retires a register write this cycle
//   I_WBIdx       register retired by writeback
//   I_BrResolved  branch outcome known, new PC valid
//   O_Issue       instruction accepted into execute (combinational)
//   O_DepStall    data-hazard stall (combinational)
//   O_FetchStall  control stall (combinational)
//   O_BusyMask    bit r set while register r has pending writes (registered)
//   O_State       current FSM state
//   O_BrTimeout   one-cycle pulse when a branch wait times out (registered)
//
// State table
//   state      | meaning
//   RUN    (0) | normal issue
//   BR_WAIT(1) | control transfer in flight, fetch held until resolve/timeout
//   HALT   (2) | I_LOCK low; everything frozen, resumes to the saved state
// -----------------------------------------------------------------------------
module hazard_scheduler #(
  parameter int NUM_REGS   = 16,
  parameter int CNT_W      = 2,
  parameter int BR_TIMEOUT = 15
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic                        I_DecValid,
  input  logic [$clog2(NUM_REGS)-1:0] I_Src1Idx,
  input  logic                        I_Src1Use,
  input  logic [$clog2(NUM_REGS)-1:0] I_Src2Idx,
  input  logic                        I_Src2Use,
  input  logic [$clog2(NUM_REGS)-1:0] I_DestIdx,
  input  logic                        I_DestWrite,
  input  logic                        I_IsCtrl,
  input  logic                        I_WBValid,
  input  logic [$clog2(NUM_REGS)-1:0] I_WBIdx,
  input  logic                        I_BrResolved,
  output logic                        O_Issue,
  output logic                        O_DepStall,
  output logic                        O_FetchStall,
  output logic [NUM_REGS-1:0]         O_BusyMask,
  output logic [1:0]                  O_State,
  output logic                        O_BrTimeout
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int TMO_W = $clog2(BR_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // The counter is compared before it increments, so the last BR_WAIT cycle
  // is the one where it already holds BR_TIMEOUT-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BR_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e              state_q;
  state_e              saved_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                br_timeout_q;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  logic                hazard;
  logic                in_run;
  logic                issue;

  // ---------------------------------------------------------------------------
  // Hazard detection and issue decision
  // ---------------------------------------------------------------------------
  // A full destination counter is treated as a hazard so the counter can never
  // wrap; the writer simply waits for a retirement.
  assign hazard = I_DecValid &
                  ((I_Src1Use   & (cnt_q[I_Src1Idx] != '0)) |
                   (I_Src2Use   & (cnt_q[I_Src2Idx] != '0)) |
                   (I_DestWrite & (cnt_q[I_DestIdx] == CNT_MAX)));

  assign in_run = (state_q == ST_RUN);
  assign issue  = I_LOCK & I_DecValid & in_run & ~hazard;

  assign O_Issue      = issue;
  assign O_DepStall   = I_LOCK & in_run & hazard;
  assign O_FetchStall = I_LOCK & ((state_q == ST_BR_WAIT) | (issue & I_IsCtrl));

  assign O_BusyMask  = busy_q;
  assign O_State     = state_q;
  assign O_BrTimeout = br_timeout_q;

  // ---------------------------------------------------------------------------
  // Scoreboard next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && I_DestWrite) begin
      inc_vec[I_DestIdx] = 1'b1;
    end
    // Retirement is judged on the count before this edge's issue, so a
    // writeback to an idle register is dropped even if the same register is
    // being issued in this cycle.
    if (I_LOCK && I_WBValid && (cnt_q[I_WBIdx] != '0)) begin
      dec_vec[I_WBIdx] = 1'b1;
    end
  end

  always_comb begin
    busy_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      case ({inc_vec[r], dec_vec[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_W'(1);
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_W'(1);
        default: cnt_d[r] = cnt_q[r];
      endcase
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered timeout pulse
  // ---------------------------------------------------------------------------
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= ST_RUN;
      saved_q      <= ST_RUN;
      tmo_q        <= '0;
      br_timeout_q <= 1'b0;
    end else begin
      // The pulse is always cleared so it lasts exactly one cycle even if the
      // pipeline locks right after it fires.
      br_timeout_q <= 1'b0;
      if (!I_LOCK) begin
        if (state_q != ST_HALT) begin
          saved_q <= state_q;
          state_q <= ST_HALT;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (issue && I_IsCtrl) begin
              state_q <= ST_BR_WAIT;
              tmo_q   <= '0;
            end
          end
          ST_BR_WAIT: begin
            if (I_BrResolved) begin
              state_q <= ST_RUN;
              tmo_q   <= '0;
            end else if (tmo_q == TMO_LAST) begin
              state_q      <= ST_RUN;
              tmo_q        <= '0;
              br_timeout_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          ST_HALT: begin
            state_q <= saved_q;
          end
          default: begin
            state_q <= ST_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  localparam int NREG    = 16;
  localparam int CNT_MAX = 3;
  localparam int TMO     = 15;

  logic        clk, rst, lock, dv, s1u, s2u, dw, ctrl, wbv, br;
  logic [3:0]  s1, s2, d, wbi;
  logic        issue, dep, fetch, btmo;
  logic [15:0] busy;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 0;

  // Behavioural model: plain integer pending counts and a state number.
  int m_cnt [NREG];
  int m_st, m_saved, m_tmo;
  bit m_btmo;

  hazard_scheduler dut (
    .I_CLOCK     (clk),
    .I_RESET     (rst),
    .I_LOCK      (lock),
    .I_DecValid  (dv),
    .I_Src1Idx   (s1),
    .I_Src1Use   (s1u),
    .I_Src2Idx   (s2),
    .I_Src2Use   (s2u),
    .I_DestIdx   (d),
    .I_DestWrite (dw),
    .I_IsCtrl    (ctrl),
    .I_WBValid   (wbv),
    .I_WBIdx     (wbi),
    .I_BrResolved(br),
    .O_Issue     (issue),
    .O_DepStall  (dep),
    .O_FetchStall(fetch),
    .O_BusyMask  (busy),
    .O_State     (state),
    .O_BrTimeout (btmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_st = 0; m_saved = 0; m_tmo = 0; m_btmo = 0;
  endfunction

  function automatic bit m_hazard();
    return dv && ((s1u && m_cnt[s1] != 0) || (s2u && m_cnt[s2] != 0) ||
                  (dw && m_cnt[d] == CNT_MAX));
  endfunction

  function automatic bit m_issue();
    return lock && dv && (m_st == 0) && !m_hazard();
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++) m[i] = (m_cnt[i] != 0);
    return m;
  endfunction

  function automatic void model_step();
    bit iss, wb_ok;
    iss   = m_issue();
    wb_ok = wbv && (m_cnt[wbi] > 0);
    m_btmo = 0;
    if (!lock) begin
      if (m_st != 2) begin
        m_saved = m_st;
        m_st    = 2;
      end
    end else begin
      if (iss && dw) m_cnt[d] = m_cnt[d] + 1;
      if (wb_ok)     m_cnt[wbi] = m_cnt[wbi] - 1;
      case (m_st)
        0: if (iss && ctrl) begin m_st = 1; m_tmo = 0; end
        1: begin
          if (br) begin
            m_st = 0; m_tmo = 0;
          end else begin
            m_tmo = m_tmo + 1;
            if (m_tmo == TMO) begin m_st = 0; m_tmo = 0; m_btmo = 1; end
          end
        end
        default: m_st = m_saved;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #3;
    if (cmp_en) begin
      chk("issue",       issue, m_issue());
      chk("dep_stall",   dep,   lock && (m_st == 0) && m_hazard());
      chk("fetch_stall", fetch, lock && ((m_st == 1) || (m_issue() && ctrl)));
      chk("busy_mask",   busy,  m_busy());
      chk("state",       state, m_st);
      chk("br_timeout",  btmo,  m_btmo);
      chk("stall_excl",  dep & fetch, 0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    lock = 1; dv = 0; s1 = 0; s1u = 0; s2 = 0; s2u = 0;
    d = 0; dw = 0; ctrl = 0; wbv = 0; wbi = 0; br = 0;
  endtask

  task automatic instr(input logic [3:0] a, input logic au, input logic [3:0] b, input logic bu,
                       input logic [3:0] dd, input logic ddw, input logic c);
    dv = 1; s1 = a; s1u = au; s2 = b; s2u = bu; d = dd; dw = ddw; ctrl = c;
  endtask

  task automatic wb(input logic [3:0] r);
    wbv = 1; wbi = r;
  endtask

  initial begin
    rst = 1; lock = 1; dv = 0; s1 = 0; s1u = 0; s2 = 0; s2u = 0;
    d = 0; dw = 0; ctrl = 0; wbv = 0; wbi = 0; br = 0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp_en = 1;
    #2;
    chk("rst_busy",  busy,  16'h0000);
    chk("rst_state", state, 2'd0);
    chk("rst_tmo",   btmo,  1'b0);

    // ADD r1 <- r2, r3
    next_cycle(); rst = 0; instr(2, 1, 3, 1, 1, 1, 0); #4;
    chk("add_issue", issue, 1'b1);
    chk("add_dep",   dep,   1'b0);
    next_cycle(); #4;
    chk("add_busy", busy, 16'h0002);

    // RAW on r1, retired by WB, issue the cycle after
    next_cycle(); instr(1, 1, 0, 0, 0, 0, 0); #4;
    chk("raw_stall", dep, 1'b1);
    chk("raw_noissue", issue, 1'b0);
    next_cycle(); instr(1, 1, 0, 0, 0, 0, 0); #4;
    chk("raw_stall2", dep, 1'b1);
    next_cycle(); instr(1, 1, 0, 0, 0, 0, 0); wb(1); #4;
    chk("raw_no_bypass", dep, 1'b1);
    chk("raw_no_bypass_iss", issue, 1'b0);
    next_cycle(); instr(1, 1, 0, 0, 0, 0, 0); #4;
    chk("raw_issue_after_wb", issue, 1'b1);
    chk("raw_busy_clear", busy, 16'h0000);

    // Same-cycle issue and WB on r4; WB to idle r7
    next_cycle(); instr(0, 0, 0, 0, 4, 1, 0); #4;
    chk("r4_issue", issue, 1'b1);
    next_cycle(); instr(0, 0, 0, 0, 4, 1, 0); wb(4); #4;
    chk("same_cycle_issue", issue, 1'b1);
    next_cycle(); wb(7); #4;
    chk("same_cycle_busy", busy, 16'h0010);
    next_cycle(); wb(4); #4;
    chk("wb_zero_ignored", busy, 16'h0010);
    next_cycle(); #4;
    chk("r4_retired", busy, 16'h0000);

    // Branch issue, wait, resolve
    next_cycle(); instr(2, 1, 0, 0, 0, 0, 1); #4;
    chk("br_issue", issue, 1'b1);
    chk("br_fetch", fetch, 1'b1);
    next_cycle(); instr(0, 0, 0, 0, 0, 0, 0); #4;
    chk("brwait_state", state, 2'd1);
    chk("brwait_fetch", fetch, 1'b1);
    chk("brwait_noissue", issue, 1'b0);
    next_cycle(); br = 1; #4;
    chk("br_resolving_state", state, 2'd1);
    next_cycle(); br = 1; #4;
    chk("br_resolved_state", state, 2'd0);
    chk("br_resolved_fetch", fetch, 1'b0);
    next_cycle(); #4;
    chk("br_in_run_ignored", state, 2'd0);

    // Branch timeout after 15 unresolved cycles
    next_cycle(); instr(0, 0, 0, 0, 0, 0, 1); #4;
    chk("tmo_issue", issue, 1'b1);
    for (int i = 0; i < TMO; i++) begin
      next_cycle(); #4;
      chk("tmo_wait_state", state, 2'd1);
      chk("tmo_wait_pulse", btmo, 1'b0);
    end
    next_cycle(); #4;
    chk("tmo_pulse", btmo, 1'b1);
    chk("tmo_state", state, 2'd0);
    next_cycle(); #4;
    chk("tmo_pulse_end", btmo, 1'b0);

    // Saturate r5, then lock/HALT with frozen counters
    for (int i = 0; i < 3; i++) begin
      next_cycle(); instr(0, 0, 0, 0, 5, 1, 0); #4;
      chk("r5_write_issue", issue, 1'b1);
    end
    next_cycle(); instr(0, 0, 0, 0, 5, 1, 0); #4;
    chk("sat_stall", dep, 1'b1);
    chk("sat_noissue", issue, 1'b0);
    next_cycle(); instr(0, 0, 0, 0, 5, 1, 0); lock = 0; #4;
    chk("lock_noissue", issue, 1'b0);
    chk("lock_nodep", dep, 1'b0);
    next_cycle(); lock = 0; wb(5); #4;
    chk("halt_state", state, 2'd2);
    chk("halt_busy", busy, 16'h0020);
    next_cycle(); lock = 0; wb(5); #4;
    chk("halt_state2", state, 2'd2);
    next_cycle(); #4;
    chk("halt_exit_cycle", state, 2'd2);
    next_cycle(); instr(0, 0, 0, 0, 5, 1, 0); #4;
    chk("halt_resumed", state, 2'd0);
    chk("halt_frozen_busy", busy, 16'h0020);
    chk("halt_frozen_sat", dep, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); wb(5);
    end
    next_cycle(); #4;
    chk("r5_drained", busy, 16'h0000);

    // Reset in BR_WAIT
    next_cycle(); instr(0, 0, 0, 0, 6, 1, 1); #4;
    chk("jsr_issue", issue, 1'b1);
    next_cycle(); #4;
    chk("jsr_wait_state", state, 2'd1);
    chk("jsr_busy", busy, 16'h0040);
    #2; rst = 1; model_reset(); #1;
    chk("rst_br_state", state, 2'd0);
    chk("rst_br_busy", busy, 16'h0000);
    next_cycle(); rst = 0;

    // Randomized traffic with small register range to force collisions
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst = ($urandom_range(0, 299) == 0);
      if (rst) model_reset();
      lock = ($urandom_range(0, 9) != 0);
      dv   = ($urandom_range(0, 9) < 7);
      s1   = 4'($urandom_range(0, 7));
      s1u  = 1'($urandom_range(0, 1));
      s2   = 4'($urandom_range(0, 7));
      s2u  = 1'($urandom_range(0, 1));
      d    = 4'($urandom_range(0, 7));
      dw   = ($urandom_range(0, 9) < 6);
      ctrl = ($urandom_range(0, 9) == 0);
      wbv  = ($urandom_range(0, 9) < 4);
      wbi  = 4'($urandom_range(0, 7));
      br   = ($urandom_range(0, 99) < 12);
    end
    next_cycle(); rst = 0;
    next_cycle();
    #4;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
